// File: rtl/rv32i_mem_arbiter.sv
// Arbiter sharing one fixed-latency single-port memory between the fetch and
// load/store stages: one transaction in flight, D has priority, IF is starvation-guarded.
module rv32i_mem_arbiter #(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            RN,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [DW-1:0]   if_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_wstrb,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [DW-1:0]   d_rdata,
  output logic            mem_en,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wstrb,
  input  logic [DW-1:0]   mem_rdata
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       owner_q, owner_d;        // 1 = D owns the in-flight transaction
  logic       owner_we_q, owner_we_d;
  logic [3:0] starve_q, starve_d;

  logic starved;
  logic grant_d;
  logic grant_if;
  logic rsp_fire;

  assign starved  = if_req && (starve_q == 4'(STARVE_MAX));
  assign grant_d  = (state_q == IDLE) && d_req && !starved;
  assign grant_if = (state_q == IDLE) && if_req && !grant_d;
  assign rsp_fire = (state_q == WAIT) && (cnt_q == 4'd0);

  always_ff @(posedge clk) begin
    if (RN) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      owner_q    <= 1'b0;
      owner_we_q <= 1'b0;
      starve_q   <= 4'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      owner_q    <= owner_d;
      owner_we_q <= owner_we_d;
      starve_q   <= starve_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    owner_d    = owner_q;
    owner_we_d = owner_we_q;
    starve_d   = starve_q;
    case (state_q)
      IDLE: begin
        if (grant_d || grant_if) begin
          state_d    = WAIT;
          cnt_d      = 4'(MEM_LAT - 1);
          owner_d    = grant_d;
          owner_we_d = grant_d && d_we;
        end
        // Only D wins that happen while IF waits count towards starvation
        if (!if_req || grant_if) begin
          starve_d = 4'd0;
        end else if (grant_d && (starve_q != 4'hF)) begin
          starve_d = starve_q + 4'd1;
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    if_rvalid = 1'b0;
    d_rvalid  = 1'b0;
    if_rdata  = '0;
    d_rdata   = '0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    if (!RN) begin
      if (grant_d) begin
        d_gnt     = 1'b1;
        mem_en    = 1'b1;
        mem_we    = d_we;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        mem_wstrb = d_wstrb;
      end else if (grant_if) begin
        if_gnt   = 1'b1;
        mem_en   = 1'b1;
        mem_addr = if_addr;
      end
      // Write completions are acknowledged with zero data
      if (rsp_fire) begin
        if (owner_q) begin
          d_rvalid = 1'b1;
          d_rdata  = owner_we_q ? '0 : mem_rdata;
        end else begin
          if_rvalid = 1'b1;
          if_rdata  = mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Scoreboard bench for rv32i_mem_arbiter: directed stimulus pushes expected grants
// and responses; a negedge monitor pops and compares them against the DUT.
module tb_rv32i_mem_arbiter;

  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 4;
  localparam logic [31:0] JUNK = 32'hCAFE_0000;

  typedef struct {
    int          cyc;
    logic        is_d;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } gnt_t;

  typedef struct {
    int          cyc;
    logic        is_d;
    logic [31:0] rdata;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rn;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  gnt_t exp_gnt_q[$];
  rsp_t exp_rsp_q[$];
  gnt_t mon_g;
  rsp_t mon_r;
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;
  int   c;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  rv32i_mem_arbiter #(
    .AW(32), .DW(32), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .RN(rn),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wstrb(d_wstrb), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
  );

  // Memory model: read data appears MEM_LAT cycles after mem_en, junk otherwise
  logic [31:0] mem_arr [64];
  logic [31:0] pipe [MEM_LAT];
  logic        mem_loaded = 1'b0;

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 64; i++) mem_arr[i] <= 32'h1000_0000 | 32'(i);
      mem_arr[4]  <= 32'h00A0_0093;
      mem_arr[16] <= 32'h1234_5678;
      mem_loaded  <= 1'b1;
    end else if (mem_en && mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_wstrb[b]) mem_arr[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    pipe[0] <= mem_en ? mem_arr[mem_addr[7:2]] : JUNK;
    for (int k = 1; k < MEM_LAT; k++) pipe[k] <= pipe[k-1];
  end

  assign mem_rdata = pipe[MEM_LAT-1];

  task automatic checkOutput(input string name, input logic [159:0] act, input logic [159:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic ifr, input logic [31:0] ifa, input logic dr,
                               input logic dwe, input logic [31:0] da,
                               input logic [31:0] dwd, input logic [3:0] dws);
    if_req  = ifr;
    if_addr = ifa;
    d_req   = dr;
    d_we    = dwe;
    d_addr  = da;
    d_wdata = dwd;
    d_wstrb = dws;
  endtask

  task automatic next_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_gnt(input int ec, input logic is_d, input logic [31:0] addr,
                            input logic we, input logic [31:0] wdata, input logic [3:0] wstrb);
    exp_gnt_q.push_back('{ec, is_d, addr, we, wdata, wstrb});
  endtask

  task automatic expect_rsp(input int ec, input logic is_d, input logic [31:0] rdata);
    exp_rsp_q.push_back('{ec, is_d, rdata});
  endtask

  always @(negedge clk) begin
    if (rn) begin
      checkOutput("reset_outputs_zero",
        160'({if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
              mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb}), 160'(0));
    end else begin
      while (exp_gnt_q.size() > 0 && exp_gnt_q[0].cyc < cyc) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL grant_missing: got none, required grant (d=%0b) at cycle %0d",
                 exp_gnt_q[0].is_d, exp_gnt_q[0].cyc);
        exp_gnt_q.delete(0);
      end
      while (exp_rsp_q.size() > 0 && exp_rsp_q[0].cyc < cyc) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL rvalid_missing: got none, required rvalid (d=%0b) at cycle %0d",
                 exp_rsp_q[0].is_d, exp_rsp_q[0].cyc);
        exp_rsp_q.delete(0);
      end

      if (if_gnt || d_gnt || mem_en) begin
        if (exp_gnt_q.size() == 0 || exp_gnt_q[0].cyc != cyc) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL grant_unexpected at cycle %0d: got if_gnt=%0b d_gnt=%0b mem_en=%0b, required none",
                   cyc, if_gnt, d_gnt, mem_en);
        end else begin
          mon_g = exp_gnt_q.pop_front();
          checkOutput("grant",
            160'({if_gnt, d_gnt, mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb}),
            160'({!mon_g.is_d, mon_g.is_d, 1'b1, mon_g.we, mon_g.addr, mon_g.wdata, mon_g.wstrb}));
        end
      end else begin
        checkOutput("idle_mem_outputs",
          160'({mem_we, mem_addr, mem_wdata, mem_wstrb}), 160'(0));
      end

      if (if_rvalid || d_rvalid) begin
        if (exp_rsp_q.size() == 0 || exp_rsp_q[0].cyc != cyc) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL rvalid_unexpected at cycle %0d: got if_rvalid=%0b d_rvalid=%0b, required none",
                   cyc, if_rvalid, d_rvalid);
        end else begin
          mon_r = exp_rsp_q.pop_front();
          checkOutput("response",
            160'({if_rvalid, d_rvalid, if_rdata, d_rdata}),
            160'({!mon_r.is_d, mon_r.is_d,
                  mon_r.is_d ? 32'h0 : mon_r.rdata, mon_r.is_d ? mon_r.rdata : 32'h0}));
        end
      end else begin
        checkOutput("idle_rdata_zero", 160'({if_rdata, d_rdata}), 160'(0));
      end
    end
  end

  initial begin
    rn = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    next_cycles(1);

    // Both requesting under reset; D wins first once reset drops, IF follows
    applyStimulus(1'b1, 32'h10, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
    next_cycles(2);
    rn = 1'b0;
    c  = cyc;
    expect_gnt(c, 1'b1, 32'h40, 1'b0, 32'h0, 4'h0);
    expect_rsp(c + 2, 1'b1, 32'h1234_5678);
    expect_gnt(c + 3, 1'b0, 32'h10, 1'b0, 32'h0, 4'h0);
    expect_rsp(c + 5, 1'b0, 32'h00A0_0093);
    next_cycles(1);
    applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    next_cycles(3);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    next_cycles(3);

    c = cyc;
    applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    expect_gnt(c, 1'b0, 32'h10, 1'b0, 32'h0, 4'h0);
    expect_rsp(c + 2, 1'b0, 32'h00A0_0093);
    next_cycles(1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    next_cycles(3);

    // Continuous contention: four D grants, then IF is forced, then D again
    c = cyc;
    applyStimulus(1'b1, 32'h10, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
    for (int k = 0; k < 4; k++) begin
      expect_gnt(c + 3*k, 1'b1, 32'h40, 1'b0, 32'h0, 4'h0);
      expect_rsp(c + 3*k + 2, 1'b1, 32'h1234_5678);
    end
    expect_gnt(c + 12, 1'b0, 32'h10, 1'b0, 32'h0, 4'h0);
    expect_rsp(c + 14, 1'b0, 32'h00A0_0093);
    expect_gnt(c + 15, 1'b1, 32'h40, 1'b0, 32'h0, 4'h0);
    expect_rsp(c + 17, 1'b1, 32'h1234_5678);
    next_cycles(16);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    next_cycles(3);

    // Full write, read-back, partial-strobe write, read-back
    c = cyc;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h80, 32'hDEAD_BEEF, 4'hF);
    expect_gnt(c, 1'b1, 32'h80, 1'b1, 32'hDEAD_BEEF, 4'hF);
    expect_rsp(c + 2, 1'b1, 32'h0);
    next_cycles(1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    next_cycles(2);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h80, 32'h0, 4'h0);
    expect_gnt(c + 3, 1'b1, 32'h80, 1'b0, 32'h0, 4'h0);
    expect_rsp(c + 5, 1'b1, 32'hDEAD_BEEF);
    next_cycles(1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h84, 32'hAABB_CCDD, 4'h3);
    expect_gnt(c + 6, 1'b1, 32'h84, 1'b1, 32'hAABB_CCDD, 4'h3);
    expect_rsp(c + 8, 1'b1, 32'h0);
    next_cycles(3);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h84, 32'h0, 4'h0);
    expect_gnt(c + 9, 1'b1, 32'h84, 1'b0, 32'h0, 4'h0);
    expect_rsp(c + 11, 1'b1, 32'h1000_CCDD);
    next_cycles(3);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    next_cycles(3);

    // Reset lands mid-transaction: the in-flight fetch never responds
    c = cyc;
    applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    expect_gnt(c, 1'b0, 32'h10, 1'b0, 32'h0, 4'h0);
    next_cycles(1);
    rn = 1'b1;
    next_cycles(1);
    rn = 1'b0;
    expect_gnt(c + 2, 1'b0, 32'h10, 1'b0, 32'h0, 4'h0);
    expect_rsp(c + 4, 1'b0, 32'h00A0_0093);
    next_cycles(1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    next_cycles(4);

    checkOutput("pending_grants", 160'(exp_gnt_q.size()), 160'(0));
    checkOutput("pending_responses", 160'(exp_rsp_q.size()), 160'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/rv32i_mem_arbiter.md
Name: rv32i_mem_arbiter

Overview:
- Shares one single-port, fixed-latency instruction/data memory between the iiitb_rv32i fetch stage (IF) and load/store stage (D).
- Sequences one outstanding memory transaction at a time.
- Gives D priority, with a starvation guard so fetch always makes progress.
- Sits between the core's IF/MEM stages and the memory macro, in the same clk/RN domain as the core.

Parameters:
- AW, 32, address width.
- DW, 32, data width (byte strobes are DW/8 bits).
- MEM_LAT, 2, cycles from mem_en to valid mem_rdata; legal range 1..15.
- STARVE_MAX, 4, consecutive D grants allowed while if_req is pending before IF is forced; legal range 1..15.

Ports:
- clk  input  1  clock, rising edge.
- RN  input  1  reset, synchronous, active-high.
- if_req  input  1  fetch request.
- if_addr  input  AW  fetch address.
- if_gnt  output  1  fetch request accepted this cycle.
- if_rvalid  output  1  fetch data valid.
- if_rdata  output  DW  fetch data.
- d_req  input  1  data request.
- d_we  input  1  1 = write, 0 = read.
- d_addr  input  AW  data address.
- d_wdata  input  DW  write data.
- d_wstrb  input  DW/8  byte enables for writes.
- d_gnt  output  1  data request accepted this cycle.
- d_rvalid  output  1  read data valid, or write completion.
- d_rdata  output  DW  read data.
- mem_en  output  1  memory access strobe, one cycle.
- mem_we  output  1  memory write enable.
- mem_addr  output  AW  memory address.
- mem_wdata  output  DW  memory write data.
- mem_wstrb  output  DW/8  memory byte enables.
- mem_rdata  input  DW  memory read data, valid MEM_LAT cycles after mem_en.

Behaviour:
- Reset: clk is the only clock. RN is synchronous and active-high. While RN is sampled high at a rising edge:
  - FSM goes to IDLE.
  - Latency counter, owner flag, owner_we and starve counter clear to 0.
- While RN is high, all outputs are forced to 0, including the combinational gnt and mem_* outputs.
- FSM states: IDLE and WAIT.
- IDLE, cycle t:
  - If no request is pending, all outputs are 0.
  - Otherwise exactly one gnt is high combinationally in cycle t.
  - In the same cycle, mem_en=1 and mem_addr/we/wdata/wstrb are driven from the winner.
  - For an IF grant: mem_we=0 and mem_wstrb=0.
  - Next state is WAIT; cnt loads MEM_LAT-1; owner and owner_we are latched.
- Arbitration:
  - Default winner is D when d_req=1.
  - If if_req=1 and starve==STARVE_MAX, IF wins.
  - Starve counter: +1 (saturating) on each D grant made while if_req=1. Clears on an IF grant, and on any arbitration cycle with if_req=0.
- WAIT:
  - If cnt!=0, cnt decrements; no gnt; mem_en=0.
  - If cnt==0, the owner's rvalid is high for exactly one cycle, then next state is IDLE.
  - The earliest next grant is therefore at t+MEM_LAT+1.
- rdata:
  - rdata = mem_rdata when the owner's rvalid=1 and owner_we=0; otherwise 0.
  - The non-owner's rvalid and rdata are always 0.
- Write ack: a D write still produces d_rvalid at t+MEM_LAT, with d_rdata=0.
- Requester rules:
  - req, addr and wdata must be held stable until gnt.
  - After gnt the requester may drop or change them; the arbiter does not sample them again for that transaction.
  - A req asserted during WAIT is ignored until IDLE.
- Idle mem outputs: when mem_en=0, mem_we, mem_addr, mem_wdata and mem_wstrb are 0.
- Reset mid-transaction: the in-flight response is discarded and no rvalid is issued. mem_rdata arriving later is ignored.
- Latency: grant to rvalid is exactly MEM_LAT cycles; throughput is one transaction per MEM_LAT+1 cycles.

Test Plan:
1. Reset values: RN=1 for 2 cycles with if_req=d_req=1 -> all outputs 0 throughout. First grant (d_gnt) occurs in the first cycle with RN=0.
2. Single IF read, MEM_LAT=2: if_req=1, if_addr=0x10, memory word 0x00A00093 at that address -> if_gnt and mem_en high at t with mem_addr=0x10, mem_we=0. if_rvalid=1 at t+2 with if_rdata=0x00A00093. d_* outputs stay 0.
3. Simultaneous requests: if_req=d_req=1, d read at 0x40 -> d_gnt at t, d_rvalid at t+2, if_gnt at t+3, if_rvalid at t+5.
4. Starvation, STARVE_MAX=4: d_req and if_req held high continuously -> D granted at t, t+3, t+6, t+9. IF granted at t+12, then D granted again at t+15.
5. Write ack: d_we=1, d_addr=0x80, d_wdata=0xDEADBEEF, d_wstrb=0xF -> mem_en=mem_we=1 with those values at t. d_rvalid=1 with d_rdata=0 at t+2, and a later read of 0x80 returns 0xDEADBEEF.
6. Reset mid-op: IF grant at t, RN=1 at the t+1 edge -> no if_rvalid at t+2. With RN released and if_req=1, the next if_gnt occurs in the first cycle after release.
